hash_soc_host: RTL and testbench

//  Host-side master for the byte-serial SocHashing port: takes a whole message word, streams it
//  MSB-byte-first, pulses start, waits for ready, reads the digest back byte by byte.

---
 rtl/ascon_soc_pkg.sv | 25 ++
 rtl/soc_strobe_seq.sv | 28 ++
 rtl/hash_soc_host.sv | 153 +++++++++++++++
 tb/tb_hash_soc_host.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_soc_pkg.sv
// rtl/ascon_soc_pkg.sv - shared state encoding and sizing helpers for the SoC hashing host
package ascon_soc_pkg;

    localparam int SOC_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LGAP,
        S_START,
        S_WAIT,
        S_RD,
        S_RWAIT,
        S_DONE
    } host_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/soc_strobe_seq.sv
// rtl/soc_strobe_seq.sv - post-strobe gap timer shared by the input-byte and digest-read phases
module soc_strobe_seq
    import ascon_soc_pkg::*;
#(
    parameter int GAP      = 3,
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic sample,
    output logic gap_last
);

    localparam int CW = clog2(GAP + 1);

    logic [CW-1:0] cnt;

    // Restarts on every strobe cycle, so each gap counts from zero.
    always_ff @(posedge clk) begin
        if (rst || !hold) cnt <= '0;
        else              cnt <= cnt + CW'(1);
    end

    assign sample   = hold && (cnt == CW'(READ_LAT - 1));
    assign gap_last = hold && (cnt == CW'(GAP - 1));

endmodule

// File: rtl/hash_soc_host.sv
// rtl/hash_soc_host.sv - word-to-byte-serial host master for the SocHashing port
module hash_soc_host
    import ascon_soc_pkg::*;
#(
    parameter int Y         = 40,
    parameter int L         = 256,
    parameter int GAP       = 3,
    parameter int START_LEN = 4,
    parameter int READ_LAT  = 1,
    parameter int TIMEOUT   = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [Y-1:0]          req_message,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [L-1:0]          rsp_digest,
    output logic                  rsp_error,
    output logic                  reg_inputxSS,
    output logic [SOC_BYTE_W-1:0] messagexSO,
    output logic                  reg_startxSS,
    output logic                  hash_startxSO,
    input  logic                  hash_readyxSI,
    output logic                  reg_outxSS,
    input  logic [SOC_BYTE_W-1:0] hash_digestxSI
);

    // The message is always followed by one all-zero byte; a partial byte is low-zero-filled.
    localparam int NIN  = (Y + SOC_BYTE_W - 1) / SOC_BYTE_W + 1;
    localparam int MW   = NIN * SOC_BYTE_W;
    localparam int NOUT = L / SOC_BYTE_W;
    localparam int KW   = clog2(NIN);
    localparam int JW   = clog2(NOUT);
    localparam int TW   = clog2((TIMEOUT > START_LEN) ? TIMEOUT : START_LEN);

    host_state_e   state, state_n;
    logic [MW-1:0] msg_sr;
    logic [L-1:0]  digest;
    logic [KW-1:0] k;
    logic [JW-1:0] j;
    logic [TW-1:0] timer;
    logic          err;
    logic          hold, sample, gap_last;

    assign hold = (state == S_LGAP) || (state == S_RWAIT);

    soc_strobe_seq #(
        .GAP      (GAP),
        .READ_LAT (READ_LAT)
    ) u_seq (
        .clk      (clk),
        .rst      (rst),
        .hold     (hold),
        .sample   (sample),
        .gap_last (gap_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            msg_sr <= '0;
            digest <= '0;
            k      <= '0;
            j      <= '0;
            timer  <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    timer <= '0;
                    if (req_valid) begin
                        msg_sr <= MW'(req_message) << (MW - Y);
                        k      <= '0;
                        err    <= 1'b0;
                    end
                end
                S_LGAP: begin
                    if (gap_last) begin
                        k      <= k + KW'(1);
                        msg_sr <= msg_sr << SOC_BYTE_W;
                    end
                end
                // One timer serves both the start pulse and the ready timeout.
                S_START: timer <= (state_n == S_WAIT) ? '0 : timer + TW'(1);
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    j     <= '0;
                    if (!hash_readyxSI && timer == TW'(TIMEOUT - 1)) err <= 1'b1;
                end
                S_RWAIT: begin
                    if (sample)   digest <= {digest[L-SOC_BYTE_W-1:0], hash_digestxSI};
                    if (gap_last) j <= j + JW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n       = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_error     = 1'b0;
        reg_inputxSS  = 1'b0;
        messagexSO    = '0;
        reg_startxSS  = 1'b0;
        hash_startxSO = 1'b0;
        reg_outxSS    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_n = S_LOAD;
            end
            S_LOAD: begin
                reg_inputxSS = 1'b1;
                messagexSO   = msg_sr[MW-1 -: SOC_BYTE_W];
                state_n      = S_LGAP;
            end
            S_LGAP: begin
                messagexSO = msg_sr[MW-1 -: SOC_BYTE_W];
                if (gap_last) state_n = (k == KW'(NIN - 1)) ? S_START : S_LOAD;
            end
            S_START: begin
                reg_startxSS  = 1'b1;
                hash_startxSO = 1'b1;
                if (timer == TW'(START_LEN - 1)) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (hash_readyxSI)                    state_n = S_RD;
                else if (timer == TW'(TIMEOUT - 1))  state_n = S_DONE;
            end
            S_RD: begin
                reg_outxSS = 1'b1;
                state_n    = S_RWAIT;
            end
            S_RWAIT: begin
                if (gap_last) state_n = (j == JW'(NOUT - 1)) ? S_DONE : S_RD;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_error = err;
                if (rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign rsp_digest = digest;

endmodule

// File: tb/tb_hash_soc_host.sv
// tb/tb_hash_soc_host.sv - randomized bench for hash_soc_host against a SoC port model
module tb_hash_soc_host;

    localparam int Y         = 40;
    localparam int YB        = 12;
    localparam int L         = 256;
    localparam int GAP       = 3;
    localparam int START_LEN = 4;
    localparam int TIMEOUT   = 64;
    localparam int NIN       = (Y + 7) / 8 + 1;
    localparam int NOUT      = L / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, rsp_valid, rsp_ready, rsp_error;
    logic [Y-1:0]  req_message;
    logic [L-1:0]  rsp_digest;
    logic          reg_inputxSS, reg_startxSS, hash_startxSO, hash_readyxSI, reg_outxSS;
    logic [7:0]    messagexSO, hash_digestxSI;

    logic          req_valid_b, req_ready_b, rsp_valid_b, rsp_ready_b, rsp_error_b;
    logic [YB-1:0] req_message_b;
    logic [L-1:0]  rsp_digest_b;
    logic          reg_inputxSS_b, reg_startxSS_b, hash_startxSO_b, hash_readyxSI_b, reg_outxSS_b;
    logic [7:0]    messagexSO_b, hash_digestxSI_b;

    hash_soc_host #(.Y(Y), .L(L), .GAP(GAP), .START_LEN(START_LEN), .READ_LAT(1), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_message(req_message),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_digest(rsp_digest), .rsp_error(rsp_error),
        .reg_inputxSS(reg_inputxSS), .messagexSO(messagexSO), .reg_startxSS(reg_startxSS),
        .hash_startxSO(hash_startxSO), .hash_readyxSI(hash_readyxSI), .reg_outxSS(reg_outxSS),
        .hash_digestxSI(hash_digestxSI)
    );

    hash_soc_host #(.Y(YB), .L(L), .GAP(GAP), .START_LEN(START_LEN), .READ_LAT(1), .TIMEOUT(TIMEOUT)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_message(req_message_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_digest(rsp_digest_b), .rsp_error(rsp_error_b),
        .reg_inputxSS(reg_inputxSS_b), .messagexSO(messagexSO_b), .reg_startxSS(reg_startxSS_b),
        .hash_startxSO(hash_startxSO_b), .hash_readyxSI(hash_readyxSI_b), .reg_outxSS(reg_outxSS_b),
        .hash_digestxSI(hash_digestxSI_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]   soc_bytes [NOUT];
    logic [7:0]   obs_bytes [$];
    int           obs_in_cyc [$];
    int           obs_start, obs_out, obs_overlap, obs_smis, obs_stall_bad;
    int           acc_cyc, wait_cyc, rsp_cyc;
    logic [L-1:0] obs_digest;
    logic         obs_err, obs_got, obs_ready_after;

    function automatic logic [7:0] exp_byte(input logic [63:0] msg, input int y, input int k);
        logic [7:0] b;
        int idx;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            idx = y - 1 - 8 * k - i;
            if (idx >= 0) b[7-i] = msg[idx];
        end
        return b;
    endfunction

    function automatic logic [L-1:0] exp_digest();
        logic [L-1:0] d;
        d = '0;
        for (int i = 0; i < NOUT; i++) d[L-1-8*i -: 8] = soc_bytes[i];
        return d;
    endfunction

    // Drives one transaction, plays the SoC side and records what the host did.
    task automatic run_txn(input logic [Y-1:0] msg, input int rdy_dly, input bit give_ready, input int stall);
        int n, pend, sidx, stall_cnt;
        bit seen_start, acked, done;
        logic [63:0] r64;
        obs_bytes.delete(); obs_in_cyc.delete();
        obs_start = 0; obs_out = 0; obs_overlap = 0; obs_smis = 0; obs_stall_bad = 0;
        wait_cyc = -1; rsp_cyc = -1; obs_got = 0; obs_ready_after = 0; obs_digest = '0; obs_err = 0;
        pend = 0; sidx = 0; stall_cnt = 0; seen_start = 0; acked = 0; done = 0;
        hash_readyxSI = 0; rsp_ready = 0;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        acc_cyc = cyc; req_valid = 1; req_message = msg;
        @(posedge clk); #1;
        req_valid = 0; r64 = {$urandom(), $urandom()}; req_message = r64[Y-1:0];
        for (int c = 0; c < 4000 && !done; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (acked) rsp_ready = 0;
            if (pend == 2) begin hash_digestxSI = 8'hEE; pend = 0; end
            else if (pend == 1) begin
                hash_digestxSI = (sidx < NOUT) ? soc_bytes[sidx] : 8'hEE;
                sidx++; pend = 2;
            end
            @(negedge clk);
            if (acked) begin obs_ready_after = req_ready; done = 1; end
            else begin
                if (reg_inputxSS) begin obs_bytes.push_back(messagexSO); obs_in_cyc.push_back(cyc); end
                if (hash_startxSO) begin obs_start++; seen_start = 1; end
                if (reg_startxSS !== hash_startxSO) obs_smis++;
                if (int'(reg_inputxSS) + int'(reg_startxSS) + int'(reg_outxSS) > 1) obs_overlap++;
                if (seen_start && !hash_startxSO && wait_cyc < 0) wait_cyc = cyc;
                if (give_ready && wait_cyc >= 0 && cyc - wait_cyc == rdy_dly && obs_out == 0) hash_readyxSI = 1;
                if (reg_outxSS) begin obs_out++; pend = 1; hash_readyxSI = 0; end
                if (rsp_valid) begin
                    if (!obs_got) begin obs_got = 1; rsp_cyc = cyc; obs_digest = rsp_digest; obs_err = rsp_error; end
                    if (stall_cnt < stall) begin
                        if (rsp_digest !== obs_digest || rsp_error !== obs_err || req_ready !== 1'b0) obs_stall_bad++;
                        stall_cnt++;
                        req_valid = (stall_cnt < stall);
                        r64 = {$urandom(), $urandom()}; req_message = r64[Y-1:0];
                    end else begin
                        req_valid = 0; rsp_ready = 1; acked = 1;
                    end
                end else if (obs_got) obs_stall_bad++;
            end
        end
        req_valid = 0; rsp_ready = 0; hash_readyxSI = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0 || rsp_error !== 1'b0) begin fails++; $display("FAIL reset_rsp: got %b%b want 00", rsp_valid, rsp_error); end
        tests++; if ({reg_inputxSS, reg_startxSS, hash_startxSO, reg_outxSS} !== 4'b0) begin
            fails++; $display("FAIL reset_strobes: got %b want 0000", {reg_inputxSS, reg_startxSS, hash_startxSO, reg_outxSS}); end
        tests++; if (messagexSO !== 8'h00) begin fails++; $display("FAIL reset_message: got %h want 00", messagexSO); end
        tests++; if (rsp_digest !== '0) begin fails++; $display("FAIL reset_digest: got %h want 0", rsp_digest); end
        tests++; if (req_ready_b !== 1'b1) begin fails++; $display("FAIL reset_req_ready_b: got %b want 1", req_ready_b); end
    endtask

    task automatic test_known_vector;
        logic [7:0] exp_in [6];
        exp_in = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
        for (int i = 0; i < NOUT; i++) soc_bytes[i] = 8'(i);
        run_txn(40'h0102030405, 0, 1, 0);
        tests++; if (obs_bytes.size() != 6) begin fails++; $display("FAIL kv_nbytes: got %0d want 6", obs_bytes.size()); end
        for (int k = 0; k < 6 && k < obs_bytes.size(); k++) begin
            tests++; if (obs_bytes[k] !== exp_in[k]) begin fails++; $display("FAIL kv_byte%0d: got %h want %h", k, obs_bytes[k], exp_in[k]); end
        end
        for (int k = 1; k < obs_in_cyc.size(); k++) begin
            tests++; if (obs_in_cyc[k] - obs_in_cyc[k-1] != GAP + 1) begin
                fails++; $display("FAIL kv_spacing%0d: got %0d want %0d", k, obs_in_cyc[k] - obs_in_cyc[k-1], GAP + 1); end
        end
        tests++; if (obs_start != START_LEN || obs_smis != 0) begin fails++; $display("FAIL kv_start: got %0d (mis %0d) want %0d", obs_start, obs_smis, START_LEN); end
        tests++; if (obs_out != 32) begin fails++; $display("FAIL kv_outs: got %0d want 32", obs_out); end
        tests++; if (obs_digest !== 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f || obs_err !== 1'b0) begin
            fails++; $display("FAIL kv_digest: got %h err %b want 0001..1f err 0", obs_digest, obs_err); end
        tests++; if (!obs_got || rsp_cyc - acc_cyc != 158) begin fails++; $display("FAIL kv_latency: got %0d want 158", rsp_cyc - acc_cyc); end
        tests++; if (obs_overlap != 0) begin fails++; $display("FAIL kv_overlap: got %0d want 0", obs_overlap); end
        tests++; if (obs_ready_after !== 1'b1) begin fails++; $display("FAIL kv_ready_after: got %b want 1", obs_ready_after); end
    endtask

    task automatic test_random;
        logic [63:0] r64;
        logic [Y-1:0] msg;
        int d, nbad, exp_lat;
        for (int it = 0; it < 6; it++) begin
            r64 = {$urandom(), $urandom()}; msg = r64[Y-1:0];
            for (int i = 0; i < NOUT; i++) soc_bytes[i] = 8'($urandom());
            d = $urandom_range(0, 20);
            run_txn(msg, d, 1, 0);
            nbad = (obs_bytes.size() != NIN) ? 1 : 0;
            for (int k = 0; k < NIN && k < obs_bytes.size(); k++)
                if (obs_bytes[k] !== exp_byte(64'(msg), Y, k)) nbad++;
            tests++; if (nbad != 0) begin fails++; $display("FAIL rnd%0d_bytes: got %0d bad of %0d want 0 bad (msg %h)", it, nbad, obs_bytes.size(), msg); end
            tests++; if (obs_digest !== exp_digest() || obs_err !== 1'b0) begin
                fails++; $display("FAIL rnd%0d_digest: got %h want %h", it, obs_digest, exp_digest()); end
            exp_lat = NIN * (1 + GAP) + START_LEN + (d + 1) + NOUT * (1 + GAP) + 1;
            tests++; if (!obs_got || rsp_cyc - acc_cyc != exp_lat) begin
                fails++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, rsp_cyc - acc_cyc, exp_lat); end
            tests++; if (obs_overlap != 0 || obs_start != START_LEN || obs_out != NOUT) begin
                fails++; $display("FAIL rnd%0d_strobes: got ovl %0d start %0d out %0d want 0 %0d %0d", it, obs_overlap, obs_start, obs_out, START_LEN, NOUT); end
        end
    endtask

    task automatic test_timeout;
        logic [L-1:0] prev;
        prev = exp_digest();
        run_txn(40'hDEADBEEF01, 0, 0, 0);
        tests++; if (!obs_got || obs_err !== 1'b1) begin fails++; $display("FAIL to_error: got valid %b err %b want 1 1", obs_got, obs_err); end
        tests++; if (rsp_cyc - wait_cyc != TIMEOUT) begin fails++; $display("FAIL to_cycles: got %0d want %0d", rsp_cyc - wait_cyc, TIMEOUT); end
        tests++; if (obs_digest !== prev || obs_out != 0) begin fails++; $display("FAIL to_digest: got %h outs %0d want %h outs 0", obs_digest, obs_out, prev); end
    endtask

    task automatic test_stall;
        int extra;
        for (int i = 0; i < NOUT; i++) soc_bytes[i] = 8'($urandom());
        run_txn(40'h55AA33CC0F, 5, 1, 10);
        tests++; if (obs_stall_bad != 0) begin fails++; $display("FAIL stall_stable: got %0d bad cycles want 0", obs_stall_bad); end
        tests++; if (obs_digest !== exp_digest() || obs_err !== 1'b0) begin fails++; $display("FAIL stall_digest: got %h err %b want %h err 0", obs_digest, obs_err, exp_digest()); end
        tests++; if (obs_ready_after !== 1'b1) begin fails++; $display("FAIL stall_ready_after: got %b want 1", obs_ready_after); end
        extra = 0;
        repeat (10) begin @(negedge clk); if (reg_inputxSS || !req_ready) extra++; end
        tests++; if (extra != 0) begin fails++; $display("FAIL stall_no_new_txn: got %0d busy cycles want 0", extra); end
    endtask

    task automatic test_reset_mid;
        int seen, busy, nbad;
        seen = 0;
        @(negedge clk);
        req_valid = 1; req_message = 40'hA1B2C3D4E5;
        @(posedge clk); #1 req_valid = 0;
        for (int c = 0; c < 100 && seen < 3; c++) begin
            @(negedge clk);
            if (reg_inputxSS) seen++;
        end
        tests++; if (seen != 3) begin fails++; $display("FAIL rmid_reach: got %0d input strobes want 3", seen); end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        tests++; if ({reg_inputxSS, reg_startxSS, reg_outxSS} !== 3'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            fails++; $display("FAIL rmid_state: got strobes %b ready %b valid %b want 000 1 0", {reg_inputxSS, reg_startxSS, reg_outxSS}, req_ready, rsp_valid); end
        busy = 0;
        repeat (20) begin @(negedge clk); if (reg_inputxSS || reg_startxSS || reg_outxSS || rsp_valid) busy++; end
        tests++; if (busy != 0) begin fails++; $display("FAIL rmid_quiet: got %0d active cycles want 0", busy); end
        for (int i = 0; i < NOUT; i++) soc_bytes[i] = 8'($urandom());
        run_txn(40'h0F1E2D3C4B, 2, 1, 0);
        nbad = (obs_bytes.size() != NIN) ? 1 : 0;
        for (int k = 0; k < NIN && k < obs_bytes.size(); k++)
            if (obs_bytes[k] !== exp_byte(64'h0F1E2D3C4B, Y, k)) nbad++;
        tests++; if (nbad != 0 || obs_digest !== exp_digest()) begin
            fails++; $display("FAIL rmid_clean_run: got %0d bad bytes digest %h want 0 %h", nbad, obs_digest, exp_digest()); end
    endtask

    task automatic test_short_msg;
        logic [7:0] bq [$];
        int scnt, n;
        bit got, err, done;
        scnt = 0; got = 0; err = 0; done = 0;
        @(negedge clk);
        n = 0;
        while (!req_ready_b && n < 100) begin @(negedge clk); n++; end
        req_valid_b = 1; req_message_b = 12'hABC;
        @(posedge clk); #1 req_valid_b = 0; req_message_b = 12'h5A5;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (rsp_ready_b) begin rsp_ready_b = 0; done = 1; end
            else begin
                if (reg_inputxSS_b) bq.push_back(messagexSO_b);
                if (hash_startxSO_b) scnt++;
                if (rsp_valid_b) begin got = 1; err = rsp_error_b; rsp_ready_b = 1; end
            end
        end
        tests++; if (bq.size() != 3) begin fails++; $display("FAIL short_nbytes: got %0d want 3", bq.size()); end
        else begin
            tests++; if (bq[0] !== 8'hAB || bq[1] !== 8'hC0 || bq[2] !== 8'h00) begin
                fails++; $display("FAIL short_bytes: got %h %h %h want ab c0 00", bq[0], bq[1], bq[2]); end
        end
        tests++; if (scnt != START_LEN) begin fails++; $display("FAIL short_start_len: got %0d want %0d", scnt, START_LEN); end
        tests++; if (!got || !err) begin fails++; $display("FAIL short_timeout_rsp: got valid %b err %b want 1 1", got, err); end
    endtask

    initial begin
        rst = 1;
        req_valid = 0; req_message = '0; rsp_ready = 0; hash_readyxSI = 0; hash_digestxSI = 8'hEE;
        req_valid_b = 0; req_message_b = '0; rsp_ready_b = 0; hash_readyxSI_b = 0; hash_digestxSI_b = 8'h00;
        test_reset;
        test_known_vector;
        test_random;
        test_timeout;
        test_stall;
        test_reset_mid;
        test_short_msg;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
